// File: rtl/gate_delay_monitor.sv
// gate_delay_monitor: checks rise/fall latency of a delayed gate output against its ideal value and tracks inertial glitch suppression.
module gate_delay_monitor #(
  parameter int RISE_DLY = 2,
  parameter int FALL_DLY = 1,
  parameter int TOL      = 0,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          exp_in,
  input  logic          obs_in,
  output logic [CW-1:0] meas_dly,
  output logic          meas_dir,
  output logic          done,
  output logic          dly_err,
  output logic          leak_err,
  output logic [CW-1:0] match_cnt,
  output logic [CW-1:0] glitch_cnt
);
  if (RISE_DLY < 1 || FALL_DLY < 1 || RISE_DLY + TOL + 1 >= 2**CW || FALL_DLY + TOL + 1 >= 2**CW) begin : g_bad_param
    $error("gate_delay_monitor: delay parameters out of range for CW");
  end
  typedef enum logic [1:0] {IDLE, WAIT_RISE, WAIT_FALL, SUPP} state_t;
  localparam logic [CW-1:0] RT = CW'(RISE_DLY);
  localparam logic [CW-1:0] FT = CW'(FALL_DLY);
  localparam logic [CW-1:0] TL = CW'(TOL);
  localparam logic [CW-1:0] ONE = CW'(1);
  state_t state, state_n;
  logic exp_q, obs_q, pend, pend_n;
  logic [CW-1:0] cnt, cnt_n, tgt, tgt_n, meas_dly_n, match_cnt_n, glitch_cnt_n;
  logic meas_dir_n, done_n, dly_err_n, leak_err_n;
  logic e_edge, o_chg, lvl, wr, hit;
  logic [CW-1:0] cnt_inc, diff;
  assign e_edge  = exp_in != exp_q;
  assign o_chg   = obs_in != obs_q;
  // a deferred edge (pend) takes its direction from the already-registered level
  assign lvl     = pend ? exp_q : exp_in;
  assign wr      = state == WAIT_RISE;
  assign hit     = obs_in == wr;
  assign cnt_inc = cnt + CW'(cnt != '1);
  assign diff    = cnt >= tgt ? cnt - tgt : tgt - cnt;
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    tgt_n        = tgt;
    pend_n       = 1'b0;
    meas_dly_n   = meas_dly;
    meas_dir_n   = meas_dir;
    done_n       = 1'b0;
    dly_err_n    = 1'b0;
    leak_err_n   = 1'b0;
    match_cnt_n  = match_cnt;
    glitch_cnt_n = glitch_cnt;
    if (!en) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (pend || e_edge) begin
            state_n = lvl ? WAIT_RISE : WAIT_FALL;
            tgt_n   = lvl ? RT : FT;
            cnt_n   = ONE;
          end else if (o_chg && obs_in != exp_in) begin
            leak_err_n = 1'b1;
            done_n     = 1'b1;
          end
        end
        WAIT_RISE, WAIT_FALL: begin
          if (hit) begin
            meas_dly_n  = cnt;
            meas_dir_n  = wr;
            done_n      = 1'b1;
            dly_err_n   = diff > TL;
            match_cnt_n = match_cnt + CW'(diff <= TL && match_cnt != '1);
            pend_n      = e_edge;
            state_n     = IDLE;
          end else if (e_edge && cnt < tgt) begin
            state_n = SUPP;
            cnt_n   = ONE;
          end else if (e_edge || cnt == tgt + TL + ONE) begin
            meas_dly_n = cnt;
            meas_dir_n = wr;
            done_n     = 1'b1;
            dly_err_n  = 1'b1;
            state_n    = IDLE;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        SUPP: begin
          if (e_edge || (!o_chg && cnt >= tgt)) begin
            glitch_cnt_n = glitch_cnt + CW'(glitch_cnt != '1);
            done_n       = 1'b1;
            pend_n       = e_edge;
            state_n      = IDLE;
          end else if (o_chg) begin
            leak_err_n = 1'b1;
            done_n     = 1'b1;
            state_n    = IDLE;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      exp_q      <= 1'b0;
      obs_q      <= 1'b0;
      pend       <= 1'b0;
      cnt        <= '0;
      tgt        <= '0;
      meas_dly   <= '0;
      meas_dir   <= 1'b0;
      done       <= 1'b0;
      dly_err    <= 1'b0;
      leak_err   <= 1'b0;
      match_cnt  <= '0;
      glitch_cnt <= '0;
    end else begin
      state      <= state_n;
      exp_q      <= exp_in;
      obs_q      <= obs_in;
      pend       <= pend_n;
      cnt        <= cnt_n;
      tgt        <= tgt_n;
      meas_dly   <= meas_dly_n;
      meas_dir   <= meas_dir_n;
      done       <= done_n;
      dly_err    <= dly_err_n;
      leak_err   <= leak_err_n;
      match_cnt  <= match_cnt_n;
      glitch_cnt <= glitch_cnt_n;
    end
  end
endmodule

// File: tb/tb_gate_delay_monitor.sv
// tb_gate_delay_monitor: scoreboard bench driving a TOL=0 and a TOL=1 monitor with identical stimulus.
module tb_gate_delay_monitor;
  typedef struct {
    bit       cm;
    bit [7:0] dly;
    bit       dir;
    bit       derr;
    bit       lerr;
    bit [7:0] mc;
    bit [7:0] gc;
  } rec_t;
  logic clk = 1'b0, rst, en, exp_in, obs_in;
  logic [7:0] meas_dly[2], match_cnt[2], glitch_cnt[2];
  logic meas_dir[2], done[2], dly_err[2], leak_err[2];
  rec_t q[2][$];
  int n_chk = 0, n_pass = 0;
  int mt[2], gt[2];
  always #5 clk = ~clk;
  for (genvar i = 0; i < 2; i++) begin : g_dut
    gate_delay_monitor #(.RISE_DLY(2), .FALL_DLY(1), .TOL(i), .CW(8)) dut (
      .clk(clk), .rst(rst), .en(en), .exp_in(exp_in), .obs_in(obs_in),
      .meas_dly(meas_dly[i]), .meas_dir(meas_dir[i]), .done(done[i]),
      .dly_err(dly_err[i]), .leak_err(leak_err[i]),
      .match_cnt(match_cnt[i]), .glitch_cnt(glitch_cnt[i])
    );
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want_v);
    n_chk++;
    if (got === want_v) n_pass++;
    else $display("FAIL %s got=%0d want=%0d", tag, got, want_v);
  endtask
  task automatic step(input logic e, input logic o);
    exp_in = e;
    obs_in = o;
    @(posedge clk);
    #1;
  endtask
  // expected completion for both instances: d0/e0 for TOL=0, d1/e1 for TOL=1
  task automatic want(input bit cm, input int d0, input int d1, input bit dir,
                      input bit e0, input bit e1, input bit lk, input bit g);
    for (int i = 0; i < 2; i++) begin
      rec_t r;
      bit e = i ? e1 : e0;
      mt[i] += int'(cm && !e);
      gt[i] += int'(g);
      r.cm = cm; r.dly = 8'(i ? d1 : d0); r.dir = dir; r.derr = e; r.lerr = lk;
      r.mc = 8'(mt[i]); r.gc = 8'(gt[i]);
      q[i].push_back(r);
    end
  endtask
  task automatic chk_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s%0d_dly", tag, i), 32'(meas_dly[i]), 0);
      chk($sformatf("%s%0d_dir", tag, i), 32'(meas_dir[i]), 0);
      chk($sformatf("%s%0d_done", tag, i), 32'(done[i]), 0);
      chk($sformatf("%s%0d_derr", tag, i), 32'(dly_err[i]), 0);
      chk($sformatf("%s%0d_lerr", tag, i), 32'(leak_err[i]), 0);
      chk($sformatf("%s%0d_mc", tag, i), 32'(match_cnt[i]), 0);
      chk($sformatf("%s%0d_gc", tag, i), 32'(glitch_cnt[i]), 0);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (done[i]) begin
          if (q[i].size() == 0) begin
            chk($sformatf("unexp_done%0d", i), 1, 0);
          end else begin
            rec_t r;
            r = q[i].pop_front();
            if (r.cm) begin
              chk($sformatf("dly%0d", i), 32'(meas_dly[i]), 32'(r.dly));
              chk($sformatf("dir%0d", i), 32'(meas_dir[i]), 32'(r.dir));
            end
            chk($sformatf("derr%0d", i), 32'(dly_err[i]), 32'(r.derr));
            chk($sformatf("lerr%0d", i), 32'(leak_err[i]), 32'(r.lerr));
            chk($sformatf("mc%0d", i), 32'(match_cnt[i]), 32'(r.mc));
            chk($sformatf("gc%0d", i), 32'(glitch_cnt[i]), 32'(r.gc));
          end
        end
      end
    end
  end
  initial begin
    mt = '{0, 0};
    gt = '{0, 0};
    rst = 1'b1; en = 1'b1; exp_in = 1'b0; obs_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    rst = 1'b0;
    repeat (2) step(0, 0);
    // clean rise, latency 2
    want(1, 2, 2, 1, 0, 0, 0, 0);
    step(1, 0); step(1, 0); step(1, 1);
    repeat (3) step(1, 1);
    // clean fall, latency 1
    want(1, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1); step(0, 0);
    repeat (3) step(0, 0);
    // rise at 3: error at TOL=0, accepted at TOL=1
    want(1, 3, 3, 1, 1, 0, 0, 0);
    step(1, 0); step(1, 0); step(1, 0); step(1, 1);
    want(1, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1); step(0, 0);
    repeat (3) step(0, 0);
    // one-cycle pulse correctly suppressed
    want(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0); step(0, 0); step(0, 0); step(0, 0);
    repeat (3) step(0, 0);
    // one-cycle pulse leaking through
    want(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0); step(0, 0); step(0, 1); step(0, 0);
    repeat (3) step(0, 0);
    // timeout: cnt 3 at TOL=0, cnt 4 at TOL=1
    want(1, 3, 4, 1, 1, 1, 0, 0);
    repeat (5) step(1, 0);
    step(1, 1);
    want(1, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1); step(0, 0);
    repeat (3) step(0, 0);
    // spurious toggle while idle
    want(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1); step(0, 0);
    repeat (3) step(0, 0);
    // output due but exp reverts first
    want(1, 2, 2, 1, 1, 1, 0, 0);
    step(1, 0); step(1, 0); step(0, 0);
    repeat (3) step(0, 0);
    // obs arrives on the same cycle exp reverts; revert handled next cycle
    want(1, 2, 2, 1, 0, 0, 0, 0);
    want(1, 1, 1, 0, 0, 0, 0, 0);
    step(1, 0); step(1, 0); step(0, 1); step(0, 1); step(0, 0);
    repeat (3) step(0, 0);
    // enable dropped mid-wait aborts silently
    step(1, 0);
    en = 1'b0;
    step(1, 0);
    en = 1'b1;
    repeat (3) step(1, 0);
    want(1, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0); step(0, 0);
    repeat (3) step(0, 0);
    // asynchronous reset one cycle into a rise
    step(1, 0);
    rst = 1'b1;
    exp_in = 1'b0;
    #1;
    chk_zero("midrst");
    mt = '{0, 0};
    gt = '{0, 0};
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) step(0, 0);
    want(1, 2, 2, 1, 0, 0, 0, 0);
    step(1, 0); step(1, 0); step(1, 1);
    repeat (4) step(1, 1);
    for (int i = 0; i < 2; i++) chk($sformatf("pending%0d", i), 32'(q[i].size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/gate_delay_monitor.md
Name: gate_delay_monitor

Overview:
- Clocked checker at the observing end of a delayed gate output, such as a two-input gate modelled with separate rise and fall inertial delays.
- Compares the ideal zero-delay gate value (exp_in) against the delayed, observed gate output (obs_in).
- Measures rise and fall latency in clock cycles and flags any latency mismatch.
- Counts input pulses shorter than the inertial delay, which must be suppressed, and flags any that leak through to the output.

Parameters:
- RISE_DLY, 2, required exp_in 0->1 to obs_in 0->1 latency in cycles (1..2^CW-2).
- FALL_DLY, 1, required exp_in 1->0 to obs_in 1->0 latency in cycles (1..2^CW-2).
- TOL, 0, allowed +/- cycle deviation on the measured latency.
- CW, 8, width of the latency counter and the event counters.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  monitor enable; when 0, the FSM is held in IDLE and all counters hold.
- exp_in  in  1  ideal gate value; synchronous to clk.
- obs_in  in  1  observed, delayed gate value; synchronous to clk.
- meas_dly  out  CW  latency of the last completed transition, in cycles.
- meas_dir  out  1  direction of that transition: 1 = rise, 0 = fall.
- done  out  1  one-cycle pulse when a transition completes or fails.
- dly_err  out  1  one-cycle pulse on a latency violation or timeout.
- leak_err  out  1  one-cycle pulse when a short pulse propagates instead of being suppressed.
- match_cnt  out  CW  number of transitions accepted within tolerance; saturates at all-ones.
- glitch_cnt  out  CW  number of correctly suppressed short pulses; saturates at all-ones.

Behaviour:
- Reset values:
  - all outputs 0; state IDLE.
  - internal exp_q/obs_q = 0; latency counter cnt = 0.
- Registers:
  - exp_q and obs_q sample exp_in and obs_in every cycle.
  - An edge is detected as exp_in != exp_q.
- States: IDLE, WAIT_RISE, WAIT_FALL.
- IDLE:
  - On exp_in 0->1: go to WAIT_RISE, tgt = RISE_DLY, cnt = 1.
  - On exp_in 1->0: go to WAIT_FALL, tgt = FALL_DLY, cnt = 1.
  - An obs_in change while in IDLE with exp_in == exp_q and obs_in != exp_in is a spurious toggle: pulse leak_err and done.
- WAIT_x, evaluated each cycle with cnt incrementing; the first matching rule wins:
  1. obs_in reaches the target level (1 for rise, 0 for fall):
     - meas_dly = cnt, meas_dir = direction, pulse done.
     - If |cnt - tgt| <= TOL, increment match_cnt; otherwise pulse dly_err.
     - Go to IDLE.
  2. exp_in reverts before obs_in moves (pulse width cnt < tgt): inertial suppression expected.
     - Go to the suppression sub-check: hold for tgt cycles, counted from the revert, watching obs_in.
     - If obs_in stays unchanged: increment glitch_cnt, pulse done, go to IDLE.
     - If obs_in changes: pulse leak_err and done, go to IDLE.
  3. exp_in reverts with cnt >= tgt: the output was due but never arrived.
     - Pulse dly_err and done; meas_dly = cnt; go to IDLE.
  4. cnt == tgt+TOL+1 with no obs_in change: timeout.
     - Pulse dly_err and done; meas_dly = cnt; go to IDLE.
- Simultaneous events:
  - obs_in reaching target and exp_in reverting in the same cycle: rule 1 takes priority.
  - The revert is then processed from IDLE on the next cycle as a new edge, using the registered exp_q.
- Suppression sub-check:
  - Implemented as an extra state, SUPP.
  - A new exp_in edge arriving during SUPP completes the check as suppressed, then is taken from IDLE on the next cycle.
- Latency: done is asserted in the same cycle the deciding sample is registered; outputs are registered, so visible 1 cycle after the deciding input edge.
- Counter width:
  - cnt saturates at all-ones.
  - Parameter legality is checked at elaboration: RISE_DLY+TOL+1 < 2^CW.
- Reset mid-operation: asynchronous return to IDLE; all counters and outputs cleared; no done pulse.
- en deasserted mid-wait: abort to IDLE with no done pulse; exp_q/obs_q keep tracking.

Test Plan:
- Rise latency: RISE_DLY=2; exp_in 0->1 at cycle 10, obs_in 0->1 at cycle 12 -> done at cycle 12, meas_dly=2, meas_dir=1, match_cnt=1, no errors.
- Fall latency: FALL_DLY=1; exp_in 1->0, obs_in follows 1 cycle later -> meas_dly=1, meas_dir=0, match_cnt increments.
- Wrong latency: exp_in rise, obs_in rise after 3 cycles, TOL=0 -> dly_err pulse, meas_dly=3. Repeat with TOL=1 -> match_cnt increments, no error.
- Suppressed glitch: exp_in high for 1 cycle (RISE_DLY=2), obs_in stays 0 -> glitch_cnt=1, done pulse, no leak_err. Same pulse with obs_in pulsing -> leak_err.
- Timeout: exp_in rise, obs_in never moves -> dly_err and done at cnt=3 (RISE_DLY=2, TOL=0).
- Reset mid-wait: assert rst 1 cycle into WAIT_RISE -> all outputs 0 immediately, state IDLE; after release, a clean rise measures correctly with match_cnt=1.
